// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO.
// ASYNC_FIFO_ERR_EN selects the sticky overflow/underflow flags.
package async_fifo_pkg;

    localparam int DEF_DW          = 8;
    localparam int DEF_AW          = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_AEMPTY_TH   = 2;

`ifdef ASYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Helpers work on a wide word; callers zero-extend and truncate.
    typedef logic [31:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_param_sync.sv
// Multi-flop synchroniser carrying a Gray pointer into another
// clock domain; async active-low reset clears every stage.
module fifo_sync_ptr #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/async_fifo_param.sv
// Dual-clock FIFO with Gray pointer crossings, registered flags and levels.
// Define ASYNC_FIFO_ERR_EN to add sticky woverflow/runderflow outputs.
module async_fifo_param
    import async_fifo_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int AW          = DEF_AW,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AFULL_TH    = (1 << AW) - 2,
    parameter int AEMPTY_TH   = DEF_AEMPTY_TH
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          winc,
    input  logic [DW-1:0] wdata,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wlevel,
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          rinc,
    output logic [DW-1:0] rdata,
    output logic          rempty,
    output logic          ralmost_empty,
    output logic [AW:0]   rlevel
`ifdef ASYNC_FIFO_ERR_EN
    ,
    output logic          woverflow,
    output logic          runderflow
`endif
);

    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] AFULL_LV  = PW'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_LV = PW'(AEMPTY_TH);

    logic [DW-1:0] mem [DEPTH];

    // write domain
    logic [AW:0] wbin;
    logic [AW:0] wgray;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] wq_rgray;
    logic [AW:0] wq_rbin;
    logic [AW:0] wlevel_next;
    logic [AW:0] wfull_cmp;
    logic        wen;

    assign wen         = winc && !wfull;
    assign wbin_next   = wbin + PW'(wen);
    assign wgray_next  = PW'(bin2gray(32'(wbin_next)));
    assign wq_rbin     = PW'(gray2bin(32'(wq_rgray)));
    assign wlevel_next = wbin_next - wq_rbin;

    // Full when the writer is exactly one lap ahead of the reader.
    assign wfull_cmp = {~wq_rgray[AW:AW-1], wq_rgray[AW-2:0]};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wgray        <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbin_next;
            wgray        <= wgray_next;
            wfull        <= (wgray_next == wfull_cmp);
            walmost_full <= (wlevel_next >= AFULL_LV);
            wlevel       <= wlevel_next;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) begin
            mem[wbin[AW-1:0]] <= wdata;
        end
    end

    // read domain
    logic [AW:0] rbin;
    logic [AW:0] rgray;
    logic [AW:0] rbin_next;
    logic [AW:0] rgray_next;
    logic [AW:0] rq_wgray;
    logic [AW:0] rq_wbin;
    logic [AW:0] rlevel_next;
    logic        ren;

    assign ren         = rinc && !rempty;
    assign rbin_next   = rbin + PW'(ren);
    assign rgray_next  = PW'(bin2gray(32'(rbin_next)));
    assign rq_wbin     = PW'(gray2bin(32'(rq_wgray)));
    assign rlevel_next = rq_wbin - rbin_next;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin          <= '0;
            rgray         <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rlevel        <= '0;
            rdata         <= '0;
        end else begin
            rbin          <= rbin_next;
            rgray         <= rgray_next;
            rempty        <= (rgray_next == rq_wgray);
            ralmost_empty <= (rlevel_next <= AEMPTY_LV);
            rlevel        <= rlevel_next;
            if (ren) begin
                rdata <= mem[rbin[AW-1:0]];
            end
        end
    end

    fifo_sync_ptr #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_w2r (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (wgray),
        .q     (rq_wgray)
    );

    fifo_sync_ptr #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_r2w (
        .clk   (wclk),
        .rst_n (wrst_n),
        .d     (rgray),
        .q     (wq_rgray)
    );

`ifdef ASYNC_FIFO_ERR_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            runderflow <= 1'b0;
        end else if (rinc && rempty) begin
            runderflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_param.sv
// Directed and random bench for async_fifo_param with a queue model.
// Error-flag steps run only when ASYNC_FIFO_ERR_EN is defined.
`timescale 1ns/1ps
module tb_async_fifo_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int SYNC  = 2;

    logic          wclk = 1'b0;
    logic          rclk = 1'b0;
    logic          wrst_n;
    logic          rrst_n;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          rinc;
    logic [DW-1:0] rdata;
    logic          rempty;
    logic          ralmost_empty;
    logic [AW:0]   rlevel;
`ifdef ASYNC_FIFO_ERR_EN
    logic          woverflow;
    logic          runderflow;
`endif

    realtime w_half = 5.0;
    realtime r_half = 13.5;

    always #(w_half) wclk = ~wclk;
    always #(r_half) rclk = ~rclk;

    async_fifo_param #(
        .DW          (DW),
        .AW          (AW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .wdata         (wdata),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .wlevel        (wlevel),
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rinc          (rinc),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel)
`ifdef ASYNC_FIFO_ERR_EN
        ,
        .woverflow     (woverflow),
        .runderflow    (runderflow)
`endif
    );

    int checks = 0;
    int errors = 0;
    int q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        winc   = 1'b0;
        rinc   = 1'b0;
        wdata  = '0;
        wrst_n = 1'b0;
        rrst_n = 1'b0;
        repeat (3) @(posedge rclk);
        @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        q.delete();
    endtask

    task automatic write_one(input logic [DW-1:0] d);
        @(negedge wclk);
        winc  = 1'b1;
        wdata = d;
        @(negedge wclk);
        winc  = 1'b0;
    endtask

    task automatic read_one();
        @(negedge rclk);
        rinc = 1'b1;
        @(negedge rclk);
        rinc = 1'b0;
    endtask

    task automatic wait_rlevel(input int lvl);
        int n = 0;
        while (int'(rlevel) != lvl && n < 40) begin
            @(negedge rclk);
            n++;
        end
    endtask

    task automatic stream(input int n, input realtime wh, input realtime rh);
        w_half = wh;
        r_half = rh;
        fork
            begin
                int sent = 0;
                int cyc  = 0;
                while (sent < n && cyc < 20000) begin
                    @(negedge wclk);
                    cyc++;
                    chk("wlevel_safe", int'(int'(wlevel) >= q.size()), 1);
                    if (!wfull) begin
                        chk("no_overrun", int'(q.size() < DEPTH), 1);
                    end
                    winc  = ($urandom_range(0, 3) != 0);
                    wdata = DW'($urandom);
                    if (winc && !wfull) begin
                        q.push_back(int'(wdata));
                        sent++;
                    end
                end
                @(negedge wclk);
                winc = 1'b0;
                chk("w_count", sent, n);
            end
            begin
                int got  = 0;
                int cyc  = 0;
                int pexp = 0;
                bit pend = 1'b0;
                while (got < n && cyc < 40000) begin
                    @(negedge rclk);
                    cyc++;
                    if (pend) begin
                        chk("stream_data", int'(rdata), pexp);
                    end
                    pend = 1'b0;
                    chk("rlevel_safe", int'(int'(rlevel) <= q.size()), 1);
                    rinc = ($urandom_range(0, 2) != 0);
                    if (rinc && !rempty) begin
                        chk("no_underrun", int'(q.size() > 0), 1);
                        if (q.size() > 0) begin
                            pexp = q.pop_front();
                            pend = 1'b1;
                        end
                        got++;
                    end
                end
                @(negedge rclk);
                rinc = 1'b0;
                if (pend) begin
                    chk("stream_data", int'(rdata), pexp);
                end
                chk("r_count", got, n);
            end
        join
        repeat (SYNC + 3) @(negedge rclk);
        chk("stream_empty", int'(rempty), 1);
        chk("stream_q", q.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp;
        logic [DW-1:0] d;

        do_reset();
        @(negedge wclk);
        chk("rst_wfull", int'(wfull), 0);
        chk("rst_wafull", int'(walmost_full), 0);
        chk("rst_wlevel", int'(wlevel), 0);
        @(negedge rclk);
        chk("rst_rempty", int'(rempty), 1);
        chk("rst_raempty", int'(ralmost_empty), 1);
        chk("rst_rlevel", int'(rlevel), 0);
        chk("rst_rdata", int'(rdata), 0);

        // fill to full, then one dropped write
        for (int i = 0; i < DEPTH; i++) begin
            write_one(DW'(i));
            q.push_back(i);
            chk("fill_wlevel", int'(wlevel), i + 1);
            chk("fill_wfull", int'(wfull), int'(i == DEPTH - 1));
            chk("fill_wafull", int'(walmost_full), int'(i + 1 >= DEPTH - 2));
        end
        write_one(8'hAA);
        chk("drop_wlevel", int'(wlevel), DEPTH);
        chk("drop_wfull", int'(wfull), 1);

        wait_rlevel(DEPTH);
        chk("sync_rlevel", int'(rlevel), DEPTH);
        chk("sync_rempty", int'(rempty), 0);
        chk("sync_raempty", int'(ralmost_empty), 0);

        for (int i = 0; i < DEPTH; i++) begin
            read_one();
            exp = q.pop_front();
            chk("drain_data", int'(rdata), exp);
            chk("drain_rlevel", int'(rlevel), DEPTH - 1 - i);
            chk("drain_raempty", int'(ralmost_empty), int'(DEPTH - 1 - i <= 2));
            chk("drain_rempty", int'(rempty), int'(i == DEPTH - 1));
        end
        repeat (SYNC + 3) @(negedge wclk);
        chk("drain_wfull", int'(wfull), 0);
        chk("drain_wlevel", int'(wlevel), 0);

        // write/read pairs past two address wraps
        for (int i = 0; i < 40; i++) begin
            d = DW'($urandom);
            @(negedge wclk);
            winc  = 1'b1;
            wdata = d;
            @(posedge wclk);
            #0.1;
            winc = 1'b0;
            lat = 0;
            while (rempty && lat < 20) begin
                @(posedge rclk);
                #0.1;
                lat++;
            end
            chk("empty_latency", int'(lat <= SYNC + 1), 1);
            read_one();
            chk("wrap_data", int'(rdata), int'(d));
            chk("wrap_rempty", int'(rempty), 1);
            chk("wrap_wfull", int'(wfull), 0);
        end

        stream(500, 5.0, 13.5);
        stream(500, 13.5, 5.0);
        w_half = 5.0;
        r_half = 13.5;

`ifdef ASYNC_FIFO_ERR_EN
        do_reset();
        @(negedge rclk);
        chk("err_rst_uf", int'(runderflow), 0);
        chk("err_rst_of", int'(woverflow), 0);
        read_one();
        chk("err_uf_set", int'(runderflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            write_one(DW'(i));
        end
        chk("err_of_clear", int'(woverflow), 0);
        write_one(8'h55);
        chk("err_of_set", int'(woverflow), 1);
        repeat (4) @(negedge wclk);
        chk("err_of_hold", int'(woverflow), 1);
        chk("err_uf_hold", int'(runderflow), 1);
        do_reset();
        @(negedge wclk);
        chk("err_of_rst", int'(woverflow), 0);
        chk("err_uf_rst", int'(runderflow), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
